// File: rtl/keypad_mem_writer.sv
// keypad_mem_writer: debounced 4-digit BCD keypad entry, committed as a binary word
// to successive memory addresses until DEPTH words have been written.
module keypad_mem_writer #(
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int DEPTH = 32,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              button1,
   input  logic              button2,
   input  logic              button3,
   input  logic              button4,
   input  logic              button,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [15:0]       entry_bcd,
   output logic              busy,
   output logic              done
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, CONVERT, WRITE} state_t;
   logic [4:0] raw, press;
   assign raw = {button, button4, button3, button2, button1};
   for (genvar i = 0; i < 5; i++) begin : g_db
      logic [CW-1:0] cnt_q, cnt_d;
      logic samp_q, db_q, db_d, press_q;
      always_comb begin
         cnt_d = (raw[i] != samp_q) ? CW'(1) :
                 (cnt_q == CW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + CW'(1);
         db_d = (cnt_d == CW'(DEBOUNCE_CYCLES)) ? raw[i] : db_q;
      end
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q   <= '0;
            samp_q  <= 1'b0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            samp_q  <= raw[i];
            db_q    <= db_d;
            press_q <= db_d & ~db_q;
         end
      end
      assign press[i] = press_q;
   end
   state_t            state_q;
   logic [13:0]       acc_q, acc_d;
   logic [1:0]        k_q;
   logic [3:0]        dig;
   logic [ADDR_W-1:0] ptr_q, addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [15:0]       entry_q, entry_d;
   logic              we_q, busy_q, done_q;
   // k walks thousands..units, so the nibble offset is 4*(3-k)
   assign dig   = entry_q[{~k_q, 2'b00} +: 4];
   assign acc_d = acc_q * 14'd10 + {10'd0, dig};
   always_comb begin
      entry_d = entry_q;
      for (int j = 0; j < 4; j++)
         if (press[j])
            entry_d[12-4*j +: 4] = (entry_q[12-4*j +: 4] == 4'd9) ? 4'd0 : entry_q[12-4*j +: 4] + 4'd1;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         k_q     <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         entry_q <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (press[4] && !done_q) begin
                  state_q <= CONVERT;
                  acc_q   <= '0;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
               end else begin
                  entry_q <= entry_d;
               end
            end
            CONVERT: begin
               acc_q <= acc_d;
               k_q   <= k_q + 2'd1;
               if (k_q == 2'd3) begin
                  state_q <= WRITE;
                  we_q    <= 1'b1;
                  addr_q  <= ptr_q;
                  wdata_q <= DATA_W'(acc_d);
               end
            end
            WRITE: begin
               state_q <= IDLE;
               we_q    <= 1'b0;
               busy_q  <= 1'b0;
               entry_q <= '0;
               if (ptr_q == ADDR_W'(DEPTH - 1)) done_q <= 1'b1;
               else ptr_q <= ptr_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign entry_bcd = entry_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_keypad_mem_writer.sv
// tb_keypad_mem_writer: table vectors, directed corner sequences and random button
// traffic, all checked cycle by cycle against an event-level model of the keypad writer.
module tb_keypad_mem_writer;
   logic clk = 1'b0;
   logic reset;
   logic [4:0] btn;
   logic b1, b2, b3, b4, bc;
   logic mem_we, busy, done;
   logic [4:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [15:0] entry_bcd;
   assign {bc, b4, b3, b2, b1} = btn;
   always #5 clk = ~clk;
   keypad_mem_writer #(.DEBOUNCE_CYCLES(4), .DEPTH(32), .ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .button1(b1), .button2(b2), .button3(b3), .button4(b4),
      .button(bc), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .entry_bcd(entry_bcd), .busy(busy), .done(done)
   );
   int vectors = 0, miscompares = 0;
   // model: debounce as run lengths of raw samples, FSM as timestamps of the accepted commit
   int e, acc_e, m_val, m_ptr, m_addr, m_wdata;
   int d[4], run[5];
   bit m_we, m_busy, m_done;
   bit last[5], db[5], pend[5];
   int wr_addr[$], wr_data[$];
   typedef struct {logic [4:0] btn; int hold; logic [15:0] exp;} vec_t;
   vec_t tbl[12];
   task automatic check(string name, longint act, longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic model_reset();
      acc_e = -100; m_val = 0; m_ptr = 0; m_addr = 0; m_wdata = 0;
      m_we = 0; m_busy = 0; m_done = 0;
      for (int j = 0; j < 4; j++) d[j] = 0;
      for (int b = 0; b < 5; b++) begin run[b] = 0; last[b] = 0; db[b] = 0; pend[b] = 0; end
   endtask
   task automatic tick();
      logic [55:0] act, exp;
      bit nd;
      @(posedge clk);
      e++;
      if (reset) model_reset();
      else begin
         if (e > acc_e + 5) begin
            if (pend[4] && !m_done) begin
               acc_e = e; m_busy = 1;
               m_val = d[0] * 1000 + d[1] * 100 + d[2] * 10 + d[3];
            end else
               for (int j = 0; j < 4; j++) if (pend[j]) d[j] = (d[j] + 1) % 10;
         end
         if (e == acc_e + 4) begin m_we = 1; m_addr = m_ptr; m_wdata = m_val; end
         if (e == acc_e + 5) begin
            m_we = 0; m_busy = 0;
            for (int j = 0; j < 4; j++) d[j] = 0;
            if (m_ptr == 31) m_done = 1; else m_ptr++;
         end
         for (int b = 0; b < 5; b++) begin
            if (btn[b] == last[b]) run[b]++;
            else begin run[b] = 1; last[b] = btn[b]; end
            nd = (run[b] >= 4) ? last[b] : db[b];
            pend[b] = nd && !db[b];
            db[b] = nd;
         end
      end
      #1;
      if (mem_we) begin wr_addr.push_back(int'(mem_addr)); wr_data.push_back(int'(mem_wdata)); end
      act = {entry_bcd, mem_we, mem_addr, mem_wdata, busy, done};
      exp = {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3]), m_we, 5'(m_addr), 32'(m_wdata), m_busy, m_done};
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL model cycle %0d: got %h expected %h", e, act, exp);
      end
   endtask
   task automatic hold(logic [4:0] m, int n);
      btn = m;
      repeat (n) tick();
      btn = '0;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
   endtask
   initial begin
      int n, ws;
      e = 0; btn = '0; reset = 1'b1;
      model_reset();
      wr_addr.delete(); wr_data.delete();
      do_reset();
      check("reset_outputs", {entry_bcd, mem_we, mem_addr, mem_wdata, busy, done}, 0);
      tbl = '{'{5'b00001, 3, 16'h0000}, '{5'b00001, 5, 16'h1000},
              '{5'b00010, 5, 16'h1100}, '{5'b00010, 6, 16'h1200},
              '{5'b00100, 5, 16'h1210}, '{5'b00100, 7, 16'h1220},
              '{5'b00100, 5, 16'h1230}, '{5'b01000, 5, 16'h1231},
              '{5'b01000, 5, 16'h1232}, '{5'b01000, 8, 16'h1233},
              '{5'b01000, 5, 16'h1234}, '{5'b10000, 5, 16'h0000}};
      for (int i = 0; i < 12; i++) begin
         hold(tbl[i].btn, tbl[i].hold);
         repeat (10) tick();
         check($sformatf("table%0d_entry", i), entry_bcd, tbl[i].exp);
      end
      check("commit_count", wr_addr.size(), 1);
      if (wr_addr.size() > 0) check("commit_word", {wr_addr[0], wr_data[0]}, {32'd0, 32'd1234});
      for (int i = 1; i <= 10; i++) begin
         hold(5'b01000, 5);
         repeat (5) tick();
         check($sformatf("wrap%0d", i), entry_bcd, i % 10);
      end
      hold(5'b00001, 5);
      repeat (5) tick();
      btn = 5'b10000; n = 0;
      while (!mem_we && n < 30) begin tick(); n++; end
      check("commit_latency", n, 9);
      check("latency_word", {mem_addr, mem_wdata}, {5'd1, 32'd1000});
      btn = '0;
      repeat (10) tick();
      do_reset();
      wr_addr.delete(); wr_data.delete();
      for (int w = 0; w < 32; w++) begin
         repeat (9) begin hold(5'b01111, 5); repeat (5) tick(); end
         if (w % 8 == 0) check($sformatf("full_entry%0d", w), entry_bcd, 16'h9999);
         hold(5'b10000, 5);
         repeat (10) tick();
      end
      check("full_count", wr_addr.size(), 32);
      for (int i = 0; i < wr_addr.size() && i < 32; i++)
         check($sformatf("full_word%0d", i), {wr_addr[i], wr_data[i]}, {i, 9999});
      check("full_done", done, 1);
      hold(5'b10000, 5);
      repeat (15) tick();
      check("commit_after_done", wr_addr.size(), 32);
      hold(5'b01000, 5);
      repeat (5) tick();
      check("edit_after_done", entry_bcd, 16'h0001);
      do_reset();
      hold(5'b00010, 5);
      repeat (5) tick();
      ws = wr_addr.size();
      btn = 5'b10000; n = 0;
      while (!busy && n < 30) begin tick(); n++; end
      check("convert_entered", busy, 1);
      btn = '0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_convert", {mem_we, mem_addr, busy}, 0);
      repeat (20) tick();
      check("reset_no_write", wr_addr.size(), ws);
      do_reset();
      for (int i = 0; i < 400; i++) begin
         btn = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
         repeat ($urandom_range(1, 8)) tick();
      end
      btn = '0;
      repeat (20) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
